// File: rtl/serial_add_sched_if.sv
// Request/result bundle for the bit-serial add scheduler: two requesters in,
// one shared result port out.
interface serial_add_sched_if #(
  parameter int unsigned WIDTH = 16
);
  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             cin0;
  logic             cin1;
  logic             gnt0;
  logic             gnt1;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             owner;

  modport master (
    output req0, req1, a0, b0, a1, b1, cin0, cin1,
    input  gnt0, gnt1, busy, done, sum, cout, owner
  );

  modport slave (
    input  req0, req1, a0, b0, a1, b1, cin0, cin1,
    output gnt0, gnt1, busy, done, sum, cout, owner
  );
endinterface

// File: rtl/serial_add_sched.sv
// Bit-serial adder shared round-robin between two requesters: one full-adder
// cell, LSB first, carry held in a register, WIDTH cycles per add.
module fulladder1 (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_sched #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  serial_add_sched_if.slave  bus
);
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, b_sh_q;
  // Bit 0 of the sum shift register would leave unread on the final edge,
  // so only the upper WIDTH-1 partial-sum bits are stored.
  logic [WIDTH-2:0] s_sh_q;
  logic [WIDTH-1:0] s_sh_d;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             last_q;
  logic             gnt0_q, gnt1_q, done_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q, owner_q;

  logic fa_s, fa_co;
  logic cnt_last;
  logic accept, win, step, fin;

  fulladder1 u_fa (
    .a  (a_sh_q[0]),
    .b  (b_sh_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  assign cnt_last = (cnt_q == CW'(WIDTH - 1));
  assign s_sh_d   = {fa_s, s_sh_q};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.req0 | bus.req1) state_d = RUN;
      RUN:     if (cnt_last)            state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    accept = (state_q == IDLE) && (bus.req0 || bus.req1);
    win    = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
    step   = (state_q == RUN);
    fin    = step && cnt_last;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      owner_q <= 1'b0;
    end else begin
      gnt0_q <= accept & ~win;
      gnt1_q <= accept & win;
      done_q <= fin;
      if (accept) begin
        a_sh_q  <= win ? bus.a1 : bus.a0;
        b_sh_q  <= win ? bus.b1 : bus.b0;
        carry_q <= win ? bus.cin1 : bus.cin0;
        cnt_q   <= '0;
        last_q  <= win;
      end else if (step) begin
        s_sh_q  <= s_sh_d[WIDTH-1:1];
        a_sh_q  <= {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_q  <= {1'b0, b_sh_q[WIDTH-1:1]};
        carry_q <= fa_co;
        cnt_q   <= cnt_q + CW'(1);
      end
      if (fin) begin
        sum_q   <= s_sh_d;
        cout_q  <= fa_co;
        owner_q <= last_q;
      end
    end
  end

  assign bus.gnt0  = gnt0_q;
  assign bus.gnt1  = gnt1_q;
  assign bus.done  = done_q;
  assign bus.busy  = (state_q != IDLE);
  assign bus.sum   = sum_q;
  assign bus.cout  = cout_q;
  assign bus.owner = owner_q;
endmodule
